// File: rtl/ps2_adb_kbd_pkg.sv
// Shared definitions for the PS/2 -> ADB keyboard stage.
//   kbd_state_t  : prefix decoder states
//   ADB_NOKEY    : keymap entry meaning "no ADB key"; events mapping here are dropped
//   ADB_CAPS     : ADB Caps Lock keycode
//   PS2_*        : set-2 prefix bytes
//   PS2_IGNORED  : keyboard response bytes that are not key events
package ps2_adb_kbd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } kbd_state_t;

  localparam logic [6:0] ADB_NOKEY = 7'h7F;
  localparam logic [6:0] ADB_CAPS  = 7'h39;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Pause is E1 followed by 7 more bytes; the counter starts at 6 and the byte seen at 0 ends it.
  localparam logic [2:0] PAUSE_SKIP = 3'd6;

  localparam logic [5:0][7:0] PS2_IGNORED = {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  function automatic logic isIgnored(input logic [7:0] b);
    for (int unsigned i = 0; i < 6; i++) begin
      if (b == PS2_IGNORED[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/ps2_adb_kbd_if.sv
// Byte-in / key-out handshake of the PS/2 -> ADB keyboard stage.
//   ps2_data/ps2_strobe : deserialised scancode byte and its valid strobe
//   key_strobe/key_data : paced ADB key event pulse and {released, keycode[6:0]}
// master = the side feeding scancodes and consuming key events; slave = ps2_adb_kbd.
interface ps2_adb_kbd_if;
  logic [7:0] ps2_data;
  logic       ps2_strobe;
  logic       key_strobe;
  logic [7:0] key_data;

  modport master (output ps2_data, output ps2_strobe, input key_strobe, input key_data);
  modport slave  (input ps2_data, input ps2_strobe, output key_strobe, output key_data);
endinterface

// File: rtl/ps2_adb_kbd_keymap.sv
// PS/2 set-2 -> ADB keycode ROM, 512 x 7, registered output.
//   clk, clk_en : clock and enable (lookup registers only on clk_en)
//   addr[8]     : E0-extended flag, addr[7:0] scancode byte
//   code        : ADB keycode, ADB_NOKEY for unmapped entries (includes E0 12 / E0 59 fake shifts)
module ps2_adb_keymap
  import ps2_adb_kbd_pkg::*;
(
  input  logic       clk,
  input  logic       clk_en,
  input  logic [8:0] addr,
  output logic [6:0] code
);

  function automatic logic [6:0] lookup(input logic [8:0] a);
    case (a)
      9'h01C: return 7'h00; 9'h01B: return 7'h01; 9'h023: return 7'h02; 9'h02B: return 7'h03;
      9'h033: return 7'h04; 9'h034: return 7'h05; 9'h01A: return 7'h06; 9'h022: return 7'h07;
      9'h021: return 7'h08; 9'h02A: return 7'h09; 9'h032: return 7'h0B; 9'h015: return 7'h0C;
      9'h01D: return 7'h0D; 9'h024: return 7'h0E; 9'h02D: return 7'h0F; 9'h035: return 7'h10;
      9'h02C: return 7'h11; 9'h016: return 7'h12; 9'h01E: return 7'h13; 9'h026: return 7'h14;
      9'h025: return 7'h15; 9'h036: return 7'h16; 9'h02E: return 7'h17; 9'h055: return 7'h18;
      9'h046: return 7'h19; 9'h03D: return 7'h1A; 9'h04E: return 7'h1B; 9'h03E: return 7'h1C;
      9'h045: return 7'h1D; 9'h05B: return 7'h1E; 9'h044: return 7'h1F; 9'h03C: return 7'h20;
      9'h054: return 7'h21; 9'h043: return 7'h22; 9'h04D: return 7'h23; 9'h05A: return 7'h24;
      9'h04B: return 7'h25; 9'h03B: return 7'h26; 9'h052: return 7'h27; 9'h042: return 7'h28;
      9'h04C: return 7'h29; 9'h05D: return 7'h2A; 9'h041: return 7'h2B; 9'h04A: return 7'h2C;
      9'h031: return 7'h2D; 9'h03A: return 7'h2E; 9'h049: return 7'h2F; 9'h00D: return 7'h30;
      9'h029: return 7'h31; 9'h00E: return 7'h32; 9'h066: return 7'h33; 9'h076: return 7'h35;
      9'h014: return 7'h36; 9'h012: return 7'h38; 9'h058: return 7'h39; 9'h011: return 7'h3A;
      9'h059: return 7'h7B; 9'h077: return 7'h47; 9'h07C: return 7'h43; 9'h079: return 7'h45;
      9'h07B: return 7'h4E; 9'h071: return 7'h41; 9'h070: return 7'h52; 9'h069: return 7'h53;
      9'h072: return 7'h54; 9'h07A: return 7'h55; 9'h06B: return 7'h56; 9'h073: return 7'h57;
      9'h074: return 7'h58; 9'h06C: return 7'h59; 9'h075: return 7'h5B; 9'h07D: return 7'h5C;
      9'h005: return 7'h7A; 9'h006: return 7'h78; 9'h004: return 7'h63; 9'h00C: return 7'h76;
      9'h003: return 7'h60; 9'h00B: return 7'h61; 9'h083: return 7'h62; 9'h00A: return 7'h64;
      9'h001: return 7'h65; 9'h009: return 7'h6D; 9'h078: return 7'h67; 9'h007: return 7'h6F;
      // E0-extended keys
      9'h175: return 7'h3E; 9'h172: return 7'h3D; 9'h16B: return 7'h3B; 9'h174: return 7'h3C;
      9'h114: return 7'h7D; 9'h111: return 7'h7C; 9'h11F: return 7'h37; 9'h127: return 7'h37;
      9'h170: return 7'h72; 9'h16C: return 7'h73; 9'h17D: return 7'h74; 9'h171: return 7'h75;
      9'h169: return 7'h77; 9'h17A: return 7'h79; 9'h14A: return 7'h4B; 9'h15A: return 7'h4C;
      default: return ADB_NOKEY;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (clk_en) code <= lookup(addr);
  end

endmodule

// File: rtl/ps2_adb_kbd.sv
// PS/2 set-2 keyboard front end for the ADB block: prefix decoding (E0/F0/E1),
// keymap translation, Caps Lock handling, event queue and output pacing.
//   clk, reset  : system clock, synchronous active-high reset
//   clk_en      : all state advances only when high
//   bus         : ps2_adb_kbd_if.slave (ps2_data/ps2_strobe in, key_strobe/key_data out)
//   caps_locked : Caps Lock state
//   q_overflow  : sticky, an event was dropped on a full queue
// Parameters: QDEPTH (queue entries, power of 2, >=2), GAP_CYCLES (min clk_en cycles between pulses, >=1).
// Build option: ADB_KBD_CAPS_TOGGLE_EN makes Caps Lock an ADB locking key (make toggles, break dropped);
// without it Caps Lock passes through and caps_locked tracks the physical key.
module ps2_adb_kbd
  import ps2_adb_kbd_pkg::*;
#(
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  ps2_adb_kbd_if.slave bus,
  output logic        caps_locked,
  output logic        q_overflow
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  // ---------------- prefix FSM ----------------
  kbd_state_t state, stateNext;
  logic [2:0] pauseCnt, pauseCntNext;
  logic       emit, emitExt, emitBrk;
  logic [7:0] psData;

  assign psData = bus.ps2_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pauseCnt <= '0;
    end else begin
      state    <= stateNext;
      pauseCnt <= pauseCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    pauseCntNext = pauseCnt;
    emit         = 1'b0;
    emitExt      = (state == ST_EXT) || (state == ST_EXTBRK);
    emitBrk      = (state == ST_BRK) || (state == ST_EXTBRK);
    if (clk_en && bus.ps2_strobe) begin
      case (state)
        ST_IDLE: begin
          if (psData == PS2_EXT)        stateNext = ST_EXT;
          else if (psData == PS2_BRK)   stateNext = ST_BRK;
          else if (psData == PS2_PAUSE) begin
            stateNext    = ST_PAUSE;
            pauseCntNext = PAUSE_SKIP;
          end else if (!isIgnored(psData)) emit = 1'b1;
        end
        ST_EXT: begin
          if (psData == PS2_BRK)      stateNext = ST_EXTBRK;
          else if (psData != PS2_EXT) begin
            emit      = 1'b1;
            stateNext = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          emit      = 1'b1;
          stateNext = ST_IDLE;
        end
        ST_PAUSE: begin
          if (pauseCnt == '0) stateNext = ST_IDLE;
          else                pauseCntNext = pauseCnt - 3'd1;
        end
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // ---------------- translation ----------------
  // The ROM registers the lookup on the emit cycle; lkValid/lkBrk travel alongside it.
  logic [6:0] romCode;
  logic       lkValid, lkBrk;

  ps2_adb_keymap keymap (
    .clk    (clk),
    .clk_en (clk_en),
    .addr   ({emitExt, psData}),
    .code   (romCode)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lkValid <= 1'b0;
      lkBrk   <= 1'b0;
    end else if (clk_en) begin
      lkValid <= emit;
      lkBrk   <= emitBrk;
    end
  end

  // ---------------- caps handling / enqueue request ----------------
  logic       enq, capsNext;
  logic [7:0] enqData;
  logic       isCaps;

  assign isCaps = (romCode == ADB_CAPS);

`ifdef ADB_KBD_CAPS_TOGGLE_EN
  logic capsHeld, heldNext;

  always_ff @(posedge clk) begin
    if (reset)       capsHeld <= 1'b0;
    else if (clk_en) capsHeld <= heldNext;
  end

  always_comb begin
    enq      = 1'b0;
    enqData  = {lkBrk, romCode};
    capsNext = caps_locked;
    heldNext = capsHeld;
    if (lkValid && romCode != ADB_NOKEY) begin
      if (!isCaps) begin
        enq = 1'b1;
      end else if (lkBrk) begin
        heldNext = 1'b0;
      end else if (!capsHeld) begin
        // Only the first make of a hold toggles; the emitted up/down bit is the old latch value.
        heldNext = 1'b1;
        capsNext = ~caps_locked;
        enq      = 1'b1;
        enqData  = {caps_locked, ADB_CAPS};
      end
    end
  end
`else
  always_comb begin
    enq      = 1'b0;
    enqData  = {lkBrk, romCode};
    capsNext = caps_locked;
    if (lkValid && romCode != ADB_NOKEY) begin
      enq = 1'b1;
      if (isCaps) capsNext = ~lkBrk;
    end
  end
`endif

  // ---------------- queue and pacer ----------------
  logic [7:0]    mem [QDEPTH];
  logic [AW:0]   wrPtr, rdPtr;
  logic [GW-1:0] gapCnt;
  logic          empty, full, doPop, doPush;
  logic          keyStrobe;
  logic [7:0]    keyData;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = clk_en && !empty && (gapCnt == '0);
  // A pop in the same cycle frees a slot, so a full queue still accepts the new event.
  assign doPush = clk_en && enq && (!full || doPop);

  always_ff @(posedge clk) begin
    if (!reset && doPush) mem[wrPtr[AW-1:0]] <= enqData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      gapCnt      <= '0;
      keyStrobe   <= 1'b0;
      keyData     <= '1;
      caps_locked <= 1'b0;
      q_overflow  <= 1'b0;
    end else begin
      keyStrobe <= 1'b0;
      if (clk_en) begin
        caps_locked <= capsNext;
        if (doPop) begin
          keyStrobe <= 1'b1;
          keyData   <= mem[rdPtr[AW-1:0]];
          rdPtr     <= rdPtr + 1'b1;
          gapCnt    <= GAP_LOAD;
        end else if (gapCnt != '0) begin
          gapCnt <= gapCnt - 1'b1;
        end
        if (doPush)   wrPtr      <= wrPtr + 1'b1;
        else if (enq) q_overflow <= 1'b1;
      end
    end
  end

  assign bus.key_strobe = keyStrobe;
  assign bus.key_data   = keyData;

endmodule
